// File: rtl/approx_mac_pipe.sv
// approx_mac_pipe: 3-stage unsigned multiplier / MAC, exact or column-approximate per op.
// Latency 3 cycles; a stalled out_ready freezes S3 and backs up to in_ready, bubbles collapse.
module approx_mac_pipe #(
    parameter int W       = 8,
    parameter int TRUNC   = 4,
    parameter int OR_COLS = 6,
    parameter int ACC_W   = 24
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [1:0]         mode,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     product,
    output logic [ACC_W-1:0]   acc,
    output logic [1:0]         out_mode
);

    localparam int PW = 2 * W;
    localparam int NG = 4;
    localparam logic [PW-1:0] COMP = {{(PW-1){1'b0}}, 1'b1} << (TRUNC - 1);

    logic              v1_q, v2_q, v3_q;
    logic              ld1, ld2, ld3;
    logic [PW-1:0]     grp_q [NG];
    logic [PW-1:0]     grp_d [NG];
    logic [1:0]        mode1_q, mode2_q, mode3_q;
    logic              clr1_q, clr2_q;
    logic [PW-1:0]     row0_q, row1_q;
    logic [PW-1:0]     row0_d, row1_d;
    logic [PW-1:0]     prod_q, sum_d;
    logic [ACC_W-1:0]  acc_q, acc_base, acc_d;
    logic [PW-1:0]     pp_rows [W];
    logic [W-1:0]      a_sh, b_up;

    assign ld3      = v2_q && (!v3_q || out_ready);
    assign ld2      = v1_q && (!v2_q || ld3);
    assign in_ready = !v1_q || ld2;
    assign ld1      = in_valid && in_ready;

    // a_sh[i] = a[i-1], b_up[j] = b[j+1]: the odd-row partner of pp(i,j) in the same column
    assign a_sh = {a[W-2:0], 1'b0};
    assign b_up = {1'b0, b[W-1:1]};

    always_comb begin
        for (int j = 0; j < W; j++) begin
            pp_rows[j] = '0;
        end
        for (int j = 0; j < W; j++) begin
            for (int i = 0; i < W; i++) begin
                if (!mode[0] || (i + j) >= OR_COLS) begin
                    pp_rows[j][i+j] = a[i] & b[j];
                end else if ((i + j) < TRUNC) begin
                    pp_rows[j][i+j] = 1'b0;
                end else if ((j % 2) == 0) begin
                    pp_rows[j][i+j] = (a[i] & b[j]) | (a_sh[i] & b_up[j]);
                end else if ((i + 1) < W) begin
                    pp_rows[j][i+j] = 1'b0;
                end else begin
                    pp_rows[j][i+j] = a[i] & b[j];
                end
            end
        end
    end

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_d[g] = '0;
        end
        for (int j = 0; j < W; j++) begin
            grp_d[j % NG] = grp_d[j % NG] + pp_rows[j];
        end
    end

    assign row0_d = grp_q[0] + grp_q[1];
    assign row1_d = grp_q[2] + grp_q[3];

    // The accumulator only moves in S3, so back-to-back MACs chain without a hazard check
    assign sum_d    = row0_q + row1_q + (mode2_q[0] ? COMP : '0);
    assign acc_base = clr2_q ? '0 : acc_q;
    assign acc_d    = mode2_q[1] ? acc_base + ACC_W'(sum_d) : acc_base;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            mode1_q <= '0;
            mode2_q <= '0;
            mode3_q <= '0;
            clr1_q  <= 1'b0;
            clr2_q  <= 1'b0;
            row0_q  <= '0;
            row1_q  <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            for (int g = 0; g < NG; g++) begin
                grp_q[g] <= '0;
            end
        end else begin
            if (ld1) begin
                v1_q    <= 1'b1;
                mode1_q <= mode;
                clr1_q  <= acc_clr;
                for (int g = 0; g < NG; g++) begin
                    grp_q[g] <= grp_d[g];
                end
            end else if (ld2) begin
                v1_q <= 1'b0;
            end

            if (ld2) begin
                v2_q    <= 1'b1;
                mode2_q <= mode1_q;
                clr2_q  <= clr1_q;
                row0_q  <= row0_d;
                row1_q  <= row1_d;
            end else if (ld3) begin
                v2_q <= 1'b0;
            end

            if (ld3) begin
                v3_q    <= 1'b1;
                mode3_q <= mode2_q;
                prod_q  <= sum_d;
                acc_q   <= acc_d;
            end else if (out_ready) begin
                v3_q <= 1'b0;
            end
        end
    end

    assign out_valid = v3_q;
    assign product   = prod_q;
    assign acc       = acc_q;
    assign out_mode  = mode3_q;

endmodule

// File: tb/tb_approx_mac_pipe.sv
// Directed bench for approx_mac_pipe at W=8, TRUNC=4, OR_COLS=6, ACC_W=24.
module tb_approx_mac_pipe;

    localparam int W       = 8;
    localparam int TRUNC   = 4;
    localparam int OR_COLS = 6;
    localparam int ACC_W   = 24;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [1:0]         mode;
    logic               acc_clr;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     product;
    logic [ACC_W-1:0]   acc;
    logic [1:0]         out_mode;

    typedef struct {
        logic [15:0] p;
        logic [23:0] acc;
        logic [1:0]  m;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          acc_cnt  = 0;
    bit          rand_done;
    logic [23:0] macc;

    approx_mac_pipe #(.W(W), .TRUNC(TRUNC), .OR_COLS(OR_COLS), .ACC_W(ACC_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .acc       (acc),
        .out_mode  (out_mode)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Result beats are compared in order against what the stimulus queued
    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("product", 64'(product), 64'(mon_e.p));
                chk("acc", 64'(acc), 64'(mon_e.acc));
                chk("out_mode", 64'(out_mode), 64'(mon_e.m));
            end
        end
        if (in_valid && in_ready) acc_cnt++;
    end

    task automatic push_exp(input logic [15:0] ep, input logic [23:0] ea, input logic [1:0] em);
        exp_t e;
        e.p = ep;
        e.acc = ea;
        e.m = em;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] tm,
                        input logic tc, input logic [15:0] ep, input logic [23:0] ea);
        int n;
        push_exp(ep, ea, tm);
        a = ta;
        b = tb;
        mode = tm;
        acc_clr = tc;
        in_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic pbit(input logic [7:0] x, input logic [7:0] y, input int c, input int j);
        if (j < 0 || j > 7 || (c - j) < 0 || (c - j) > 7) return 1'b0;
        return x[c-j] & y[j];
    endfunction

    // Column-by-column reference: walk each column in j order and OR the (2m, 2m+1) pairs
    function automatic logic [15:0] model_prod(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
        logic [31:0] s;
        if (!m[0]) return 16'(x) * 16'(y);
        s = 32'd0;
        for (int c = TRUNC; c < 16; c++) begin
            if (c < OR_COLS) begin
                for (int j = 0; j < 8; j += 2)
                    s += 32'(pbit(x, y, c, j) | pbit(x, y, c, j + 1)) << c;
            end else begin
                for (int j = 0; j < 8; j++)
                    s += 32'(pbit(x, y, c, j)) << c;
            end
        end
        s += 32'd1 << (TRUNC - 1);
        return s[15:0];
    endfunction

    task automatic send_m(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input logic c);
        logic [15:0] p;
        p = model_prod(x, y, m);
        macc = (c ? 24'd0 : macc) + (m[1] ? 24'(p) : 24'd0);
        send(x, y, m, c, p, macc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        RST_N = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        mode = 2'b00;
        acc_clr = 1'b0;
        macc = '0;
        rand_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted at the next edge, valid three cycles on
        push_exp(16'hFE01, 24'd0, 2'b00);
        a = 8'd255; b = 8'd255; mode = 2'b00; acc_clr = 1'b0; in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        chk("lat_c1", 64'(out_valid), 64'd0);
        @(posedge CLK); #1;
        chk("lat_c2", 64'(out_valid), 64'd0);
        @(posedge CLK); #1;
        chk("lat_c3", 64'(out_valid), 64'd1);
        drain();

        // Approximate products, hand-derived
        send(8'd3,    8'd3,    2'b01, 1'b0, 16'h0008, 24'd0);
        send(8'd16,   8'd16,   2'b01, 1'b0, 16'h0108, 24'd0);
        send(8'd0,    8'd0,    2'b01, 1'b0, 16'h0008, 24'd0);
        send(8'd255,  8'd255,  2'b01, 1'b0, 16'hFD58, 24'd0);
        send(8'h18,   8'h03,   2'b01, 1'b0, 16'h0038, 24'd0);
        send(8'h0F,   8'h0F,   2'b01, 1'b0, 16'h0088, 24'd0);
        send(8'h30,   8'h01,   2'b01, 1'b0, 16'h0038, 24'd0);
        // MAC chain, MUL leaves accumulator, approx MAC, then clear via MUL
        send(8'd10,   8'd10,   2'b10, 1'b1, 16'd100,  24'd100);
        send(8'd20,   8'd5,    2'b10, 1'b0, 16'd100,  24'd200);
        send(8'd7,    8'd7,    2'b00, 1'b0, 16'd49,   24'd200);
        send(8'h18,   8'h03,   2'b11, 1'b0, 16'h0038, 24'd256);
        send(8'd2,    8'd2,    2'b00, 1'b1, 16'd4,    24'd0);
        drain();

        // Backpressure: only three ops fit while the output is blocked
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                send(8'd1, 8'd3, 2'b10, 1'b1, 16'd3,  24'd3);
                send(8'd2, 8'd3, 2'b10, 1'b0, 16'd6,  24'd9);
                send(8'd3, 8'd3, 2'b10, 1'b0, 16'd9,  24'd18);
                send(8'd4, 8'd3, 2'b10, 1'b0, 16'd12, 24'd30);
                send(8'd5, 8'd3, 2'b10, 1'b0, 16'd15, 24'd45);
            end
            begin
                repeat (6) @(posedge CLK);
                #1;
                chk("stall_accepted", 64'(acc_cnt), 64'd3);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLK);
                    chk("stream_valid", 64'(out_valid), 64'd1);
                end
            end
        join
        drain();

        // Reset with a full pipeline discards everything in flight
        out_ready = 1'b0;
        send(8'd1, 8'd1, 2'b10, 1'b0, 16'd0, 24'd0);
        send(8'd2, 8'd1, 2'b10, 1'b0, 16'd0, 24'd0);
        send(8'd3, 8'd1, 2'b10, 1'b0, 16'd0, 24'd0);
        chk("flight_full", 64'(out_valid), 64'd1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1 RST_N = 1'b1;
        exp_q.delete();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_acc", 64'(acc), 64'd0);
        chk("mid_rst_product", 64'(product), 64'd0);
        chk("mid_rst_out_mode", 64'(out_mode), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(8'd3, 8'd3, 2'b11, 1'b0, 16'h0008, 24'd8);
        drain();

        // Accumulator wrap: 259 x 0xFE01 mod 2^24
        for (int k = 0; k < 259; k++) send_m(8'd255, 8'd255, 2'b10, (k == 0));
        drain();
        chk("wrap_final", 64'(acc), 64'd64259);

        // Mixed modes under random output stalls and input gaps
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    send_m(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           2'($urandom_range(0, 3)), (k == 0) || ($urandom_range(0, 7) == 0));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge CLK);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
